note_osc: RTL

//   Square-wave tone oscillator, directly downstream of the note-to-count lookup.

---
 rtl/note_osc.sv | 111 +++++++++++
 1 files changed

// File: rtl/note_osc.sv
// note_osc: glitch-free square-wave tone oscillator driven by a half-period count.
// Rev 1.0 - initial release.
`default_nettype none

module note_osc #(
  parameter int BW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          gate_i,
  input  logic [BW-1:0] halfCntPeriod_i,
  output logic          wave_o,
  output logic          edge_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [BW-1:0] C_ONE = {{(BW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] period_q, period_d;
  logic          wave_q, wave_d;
  logic          edge_q, edge_d;
  logic          bnd;
  logic          park;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      wave_q   <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wave_q   <= wave_d;
      edge_q   <= edge_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wave_d   = wave_q;
    edge_d   = 1'b0;
    park     = 1'b0;
    // period_q is never zero outside IDLE, so the subtraction cannot wrap there
    bnd      = (state_q != IDLE) && (cnt_q == (period_q - C_ONE));

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        wave_d = 1'b0;
        if (gate_i && (halfCntPeriod_i != '0)) begin
          period_d = halfCntPeriod_i;
          wave_d   = 1'b1;
          edge_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!bnd) begin
          cnt_d = cnt_q + C_ONE;
          if (!gate_i) state_d = DRAIN;
        end else begin
          cnt_d = '0;
          if (gate_i && (halfCntPeriod_i != '0)) begin
            period_d = halfCntPeriod_i;
            wave_d   = ~wave_q;
            edge_d   = 1'b1;
          end else begin
            park = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!bnd) begin
          cnt_d = cnt_q + C_ONE;
          if (gate_i) state_d = RUN;
        end else begin
          cnt_d = '0;
          park  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Finishing a half: a high half falls (one edge), a low half just stops.
    if (park) begin
      state_d = IDLE;
      wave_d  = 1'b0;
      edge_d  = wave_q;
    end
  end

  assign wave_o = wave_q;
  assign edge_o = edge_q;
  assign busy_o = (state_q != IDLE);

endmodule

`default_nettype wire
